// File: rtl/minterm_scanner.sv
// minterm_scanner: walks every input combination of an external combinational
// function and streams out the indices where the function returns 1.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   start, abort   begin a scan (IDLE only) / cancel a running scan
//   func_in        vector driven to the function under test (MSB = input a)
//   func_out       function result for the current func_in
//   m_valid/m_ready/m_index   minterm stream, ascending index order
//   busy           high in every state except IDLE
//   done           one-cycle pulse when a scan completes
//   count          minterms accepted in the last or current scan
module minterm_scanner #(
    parameter int unsigned N_IN   = 7,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   func_in,
    input  logic              func_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_IN-1:0]   m_index,
    output logic              busy,
    output logic              done,
    output logic [N_IN:0]     count
);

    localparam int unsigned CNT_W    = N_IN + 1;
    localparam int unsigned SET_W    = 4;
    localparam logic [SET_W-1:0] SETTLE_LD = SET_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  LAST_IDX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    idx_q;
    logic [N_IN-1:0]    func_in_q;
    logic [SET_W-1:0]   settle_q;
    logic               m_valid_q;
    logic [N_IN-1:0]    m_index_q;
    logic               busy_q;
    logic               done_q;
    logic [CNT_W-1:0]   count_q;

    logic [N_IN-1:0]    idx_inc_c;
    logic               is_last_c;

    assign idx_inc_c = N_IN'(idx_q + N_IN'(1));
    assign is_last_c = (idx_q == LAST_IDX);

    // Scan sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            func_in_q <= '0;
            settle_q  <= '0;
            m_valid_q <= 1'b0;
            m_index_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_DRIVE;
                        idx_q     <= '0;
                        func_in_q <= '0;
                        count_q   <= '0;
                        settle_q  <= SETTLE_LD;
                        busy_q    <= 1'b1;
                    end
                end

                S_DRIVE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (settle_q != '0) begin
                        settle_q <= settle_q - SET_W'(1);
                    end else if (func_out) begin
                        state_q   <= S_EMIT;
                        m_valid_q <= 1'b1;
                        m_index_q <= idx_q;
                    end else if (is_last_c) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q     <= idx_inc_c;
                        func_in_q <= idx_inc_c;
                        settle_q  <= SETTLE_LD;
                    end
                end

                S_EMIT: begin
                    // abort wins over a same-cycle handshake: minterm not counted
                    if (abort) begin
                        state_q   <= S_IDLE;
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        count_q   <= count_q + CNT_W'(1);
                        if (is_last_c) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_DRIVE;
                            idx_q     <= idx_inc_c;
                            func_in_q <= idx_inc_c;
                            settle_q  <= SETTLE_LD;
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q   <= S_IDLE;
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign func_in = func_in_q;
    assign m_valid = m_valid_q;
    assign m_index = m_index_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// tb_minterm_scanner: drives two scanners (SETTLE=1 with a combinational
// function, SETTLE=3 with a function registered one cycle late) from truth
// tables and compares the minterm stream, done timing and count with a
// model built directly from the truth table.
module tb_minterm_scanner;

    localparam int unsigned N = 7;
    localparam int unsigned ROWS = 1 << N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;
    logic abort = 1'b0;
    logic m_ready = 1'b1;

    logic [ROWS-1:0] lut1 = '0;
    logic [ROWS-1:0] lut3 = '0;

    logic [N-1:0] func_in1, m_index1, func_in3, m_index3;
    logic         func_out1, m_valid1, busy1, done1;
    logic         func_out3, m_valid3, busy3, done3;
    logic [N:0]   count1, count3;
    logic         f3_q = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit sel = 1'b0;

    always #5 clk = ~clk;

    assign func_out1 = lut1[func_in1];
    always @(posedge clk) f3_q <= lut3[func_in3];
    assign func_out3 = f3_q;

    minterm_scanner #(.N_IN(N), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .func_in(func_in1), .func_out(func_out1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_index(m_index1),
        .busy(busy1), .done(done1), .count(count1)
    );

    minterm_scanner #(.N_IN(N), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort),
        .func_in(func_in3), .func_out(func_out3),
        .m_valid(m_valid3), .m_ready(m_ready), .m_index(m_index3),
        .busy(busy3), .done(done3), .count(count3)
    );

    logic         o_valid, o_busy, o_done;
    logic [N-1:0] o_index, o_fin;
    logic [N:0]   o_count;
    assign o_valid = sel ? m_valid3 : m_valid1;
    assign o_busy  = sel ? busy3    : busy1;
    assign o_done  = sel ? done3    : done1;
    assign o_index = sel ? m_index3 : m_index1;
    assign o_fin   = sel ? func_in3 : func_in1;
    assign o_count = sel ? count3   : count1;

    typedef struct {
        string           name;
        logic [ROWS-1:0] lut;
        int              stall_first;
        int              exp_count;
        int              exp_done;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit s, input bit v);
        if (s) start3 = v; else start1 = v;
    endtask

    // One full scan; expected minterms and done time come from the truth table.
    task automatic run_scan(input bit s, input string nm, input logic [ROWS-1:0] lut,
                            input int stall_first, input bit rand_ready,
                            input int settle, input int exp_done, input int mid_start);
        int n, stalls, busy_cycles, done_at, m, stall_left;
        bit prev_valid, prev_ready;
        logic [N-1:0] prev_index;
        sel = s;
        if (s) lut3 = lut; else lut1 = lut;
        exp_q.delete();
        for (int i = 0; i < int'(ROWS); i++) if (lut[i]) exp_q.push_back(i);
        m = exp_q.size();
        m_ready = 1'b1;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        n = 0; stalls = 0; busy_cycles = 0; done_at = -1;
        stall_left = stall_first; prev_valid = 1'b0; prev_ready = 1'b1; prev_index = '0;
        while (n < 2000) begin
            if (o_busy) busy_cycles++;
            if (o_done) begin
                done_at = n;
                break;
            end
            if (prev_valid && !prev_ready) check({nm, " index stable"}, int'(o_index), int'(prev_index));
            if (o_valid) check({nm, " index==func_in"}, int'(o_index), int'(o_fin));
            if (o_valid && stall_left > 0) begin
                m_ready = 1'b0;
                stall_left--;
            end else begin
                m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (o_valid && !m_ready) stalls++;
            if (o_valid && m_ready) begin
                if (exp_q.size() == 0) check({nm, " extra minterm"}, int'(o_index), -1);
                else check({nm, " minterm"}, int'(o_index), exp_q.pop_front());
            end
            if (n == mid_start) set_start(s, 1'b1);
            prev_valid = o_valid; prev_ready = m_ready; prev_index = o_index;
            tick();
            set_start(s, 1'b0);
            n++;
        end
        if (done_at < 0) begin
            check({nm, " done timeout"}, n, -1);
        end else begin
            check({nm, " done cycle"}, done_at, settle * int'(ROWS) + m + stalls);
            if (exp_done >= 0) check({nm, " done cycle fixed"}, done_at, exp_done);
            check({nm, " busy cycles"}, busy_cycles, done_at + 1);
            check({nm, " count"}, int'(o_count), m);
            check({nm, " leftover minterms"}, exp_q.size(), 0);
            // start during the DONE cycle must be ignored
            set_start(s, 1'b1);
            m_ready = 1'b1;
            tick();
            set_start(s, 1'b0);
            check({nm, " done one cycle"}, int'(o_done), 0);
            check({nm, " idle after done"}, int'(o_busy), 0);
        end
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        logic [ROWS-1:0] lut;
        vecs[0] = '{"const0",   '0, 0, 0, 128};
        vecs[1] = '{"const1",   '1, 0, 128, 256};
        vecs[2] = '{"only0",    {{(ROWS-1){1'b0}}, 1'b1}, 0, 1, 129};
        vecs[3] = '{"only127",  {1'b1, {(ROWS-1){1'b0}}}, 0, 1, 129};
        vecs[4] = '{"even",     128'h5555_5555_5555_5555_5555_5555_5555_5555, 0, 64, 192};
        lut = '0; lut[8'h55] = 1'b1; lut[8'h7F] = 1'b1;
        vecs[5] = '{"x55_x7f",  lut, 5, 2, 135};

        // reset state of both instances
        repeat (3) tick();
        check("rst func_in",  int'(func_in1), 0);
        check("rst m_valid",  int'(m_valid1), 0);
        check("rst m_index",  int'(m_index1), 0);
        check("rst busy",     int'(busy1), 0);
        check("rst done",     int'(done1), 0);
        check("rst count",    int'(count1), 0);
        check("rst3 busy",    int'({busy3, m_valid3, done3}), 0);
        rst_n = 1'b1;
        tick();

        // table vectors; const0 also gets a start pulse while busy
        for (int v = 0; v < 6; v++) begin
            run_scan(1'b0, vecs[v].name, vecs[v].lut, vecs[v].stall_first, 1'b0, 1,
                     vecs[v].exp_done, (v == 0) ? 50 : -1);
            check({vecs[v].name, " table count"}, int'(count1), vecs[v].exp_count);
        end

        // randomized truth tables with random backpressure
        for (int r = 0; r < 4; r++) begin
            lut = {$urandom, $urandom, $urandom, $urandom};
            run_scan(1'b0, "random", lut, 0, 1'b1, 1, -1, -1);
        end

        // SETTLE=3 against a function whose output lags func_in by one cycle
        lut = {$urandom, $urandom, $urandom, $urandom};
        run_scan(1'b1, "settle3", lut, 0, 1'b0, 3, -1, -1);
        lut = {$urandom, $urandom, $urandom, $urandom};
        run_scan(1'b1, "settle3_rr", lut, 0, 1'b1, 3, -1, -1);
        sel = 1'b0;

        // abort in EMIT on index 0x10 with a same-cycle handshake
        lut1 = '1;
        m_ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (m_valid1 && m_index1 == N'(16)) break;
            tick();
        end
        check("abort reached 0x10", int'(m_index1), 16);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort m_valid", int'(m_valid1), 0);
        check("abort busy",    int'(busy1), 0);
        check("abort done",    int'(done1), 0);
        check("abort count",   int'(count1), 16);
        tick();
        check("abort no done", int'(done1), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort idle busy",  int'(busy1), 0);
        check("abort idle count", int'(count1), 16);

        // asynchronous reset mid-scan, then a fresh scan from index 0
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (20) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst func_in", int'(func_in1), 0);
        check("arst m_valid", int'(m_valid1), 0);
        check("arst m_index", int'(m_index1), 0);
        check("arst busy",    int'(busy1), 0);
        check("arst count",   int'(count1), 0);
        #1 rst_n = 1'b1;
        tick();
        run_scan(1'b0, "after_reset", '1, 0, 1'b0, 1, 256, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
